// File: rtl/req_capture.sv
// req_capture
//   Turns raw, asynchronous, bouncy request lines into clean sticky pending
//   bits for the downstream priority encoder. Each line is synchronised,
//   debounced and rising-edge detected. A rising edge sets the pending bit,
//   which stays set until the consumer clears it by index or clears all bits.
//
// Ports
//   clk          system clock (the only clock)
//   rst          synchronous, active-high reset
//   req_in       raw asynchronous request lines [WIDTH]
//   mask         per-line event mask [WIDTH] (only when REQ_MASK_EN is defined)
//   clr_valid    clear pending[clr_idx] this cycle
//   clr_idx      index to clear; values >= WIDTH have no effect
//   clr_all      clear all pending bits and overflow
//   pending      sticky request vector [WIDTH]
//   pending_any  registered OR of the next pending value
//   overflow     sticky: a new edge arrived on an already-pending bit
//
// Optional feature
//   `define REQ_MASK_EN adds the mask input. A masked rising edge is dropped
//   (not deferred). Debounce keeps tracking masked lines, so unmasking a line
//   that is already held high does not create an event.

module req_capture #(
  parameter int  WIDTH           = 8,
  parameter int  SYNC_STAGES     = 2,
  parameter int  DEBOUNCE_CYCLES = 4,
  localparam int IDX_W           = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
`ifdef REQ_MASK_EN
  input  logic [WIDTH-1:0] mask,
`endif
  input  logic             clr_valid,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic             clr_all,
  output logic [WIDTH-1:0] pending,
  output logic             pending_any,
  output logic             overflow
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;

  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] deb_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] clr_hit;
  logic [WIDTH-1:0] pend_d;
  logic             ovf_set;
  logic             ovf_d;

  // ---------------------------------------------------------------------------
  // Synchroniser chain
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= req_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce: a synchronised level must differ from the debounced state for
  // DEBOUNCE_CYCLES consecutive samples. Any agreeing sample restarts the
  // count. A rise is the 0->1 acceptance itself, so it lands on the same edge
  // as the debounced state change.
  // ---------------------------------------------------------------------------
  always_comb begin
    deb_d = deb_q;
    rise  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_s[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync_s[i];
          rise[i]  = sync_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event enable
  // ---------------------------------------------------------------------------
`ifdef REQ_MASK_EN
  assign rise_en = rise & ~mask;
`else
  assign rise_en = rise;
`endif

  // ---------------------------------------------------------------------------
  // Pending / overflow next state. A rise always wins over any clear so no
  // event is ever lost. An out-of-range clr_idx matches no bit.
  // ---------------------------------------------------------------------------
  always_comb begin
    clr_hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      clr_hit[i] = clr_valid && (clr_idx == IDX_W'(i));
    end
  end

  always_comb begin
    if (clr_all) begin
      pend_d = rise_en;
    end else begin
      pend_d = rise_en | (pending & ~clr_hit);
    end
  end

  // Overflow set takes priority over clr_all on the same cycle.
  assign ovf_set = |(rise_en & pending & ~clr_hit);
  assign ovf_d   = ovf_set | (overflow & ~clr_all);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      pending_any <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      pending     <= pend_d;
      pending_any <= |pend_d;
      overflow    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_req_capture.sv
// Self-checking bench for req_capture (default parameters).
module tb_req_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic       clr_valid;
  logic [2:0] clr_idx;
  logic       clr_all;
`ifdef REQ_MASK_EN
  logic [7:0] mask;
`endif
  logic [7:0] pending;
  logic       pending_any;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int step_no = 0;

  always #5 clk = ~clk;

  req_capture dut (
    .clk         (clk),
    .rst         (rst),
    .req_in      (req_in),
`ifdef REQ_MASK_EN
    .mask        (mask),
`endif
    .clr_valid   (clr_valid),
    .clr_idx     (clr_idx),
    .clr_all     (clr_all),
    .pending     (pending),
    .pending_any (pending_any),
    .overflow    (overflow)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       cv;
    logic [2:0] ci;
    logic       ca;
    logic [7:0] ep;
    logic       ea;
    logic       eo;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] ep;
    logic       ea;
    logic       eo;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic vec_t mk(input logic r, input logic [7:0] rq, input logic cv,
                              input logic [2:0] ci, input logic ca,
                              input logic [7:0] ep, input logic eo);
    vec_t v;
    v.rst = r; v.req = rq; v.cv = cv; v.ci = ci; v.ca = ca;
    v.ep = ep; v.ea = |ep; v.eo = eo;
    return v;
  endfunction

  function automatic void add(input int n, input logic r, input logic [7:0] rq,
                              input logic cv, input logic [2:0] ci, input logic ca,
                              input logic [7:0] ep, input logic eo);
    for (int k = 0; k < n; k++) vecs.push_back(mk(r, rq, cv, ci, ca, ep, eo));
  endfunction

  task automatic check(input string name, input int id,
                       input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue what must appear after the next edge,
  // then pop and compare once the DUT has produced it.
  task automatic apply(input vec_t v);
    exp_t e;
    rst       = v.rst;
    req_in    = v.req;
    clr_valid = v.cv;
    clr_idx   = v.ci;
    clr_all   = v.ca;
    e.id = step_no; e.ep = v.ep; e.ea = v.ea; e.eo = v.eo;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("pending",     e.id, pending,              e.ep);
    check("pending_any", e.id, {7'b0, pending_any},  {7'b0, e.ea});
    check("overflow",    e.id, {7'b0, overflow},     {7'b0, e.eo});
    step_no++;
  endtask

  task automatic seq(input int n, input logic r, input logic [7:0] rq,
                     input logic cv, input logic [2:0] ci, input logic ca,
                     input logic [7:0] ep, input logic eo);
    for (int k = 0; k < n; k++) apply(mk(r, rq, cv, ci, ca, ep, eo));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_in = '0; clr_valid = 1'b0; clr_idx = '0; clr_all = 1'b0;
`ifdef REQ_MASK_EN
    mask = '0;
`endif

    //  n  rst req    cv ci ca  exp_pend ovf
    // reset
    add(2, 1, 8'h00, 0, 0, 0, 8'h00, 0);
    // clean press on bit 2: set after the 6th edge, then stable
    add(5, 0, 8'h04, 0, 0, 0, 8'h00, 0);
    add(5, 0, 8'h04, 0, 0, 0, 8'h04, 0);
    add(6, 0, 8'h00, 0, 0, 0, 8'h04, 0);
    // bit 7 press -> 8'h84, clear by index, no-op clear, clear all
    add(5, 0, 8'h80, 0, 0, 0, 8'h04, 0);
    add(1, 0, 8'h80, 0, 0, 0, 8'h84, 0);
    add(1, 0, 8'h80, 1, 7, 0, 8'h04, 0);
    add(1, 0, 8'h80, 1, 3, 0, 8'h04, 0);
    add(1, 0, 8'h80, 0, 0, 1, 8'h00, 0);
    add(6, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    // 3-cycle glitch on bit 1 is filtered
    add(3, 0, 8'h02, 0, 0, 0, 8'h00, 0);
    add(6, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    // bounce 1,0,1,1,... on bit 5: one event, timed from the last restart
    add(1, 0, 8'h20, 0, 0, 0, 8'h00, 0);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    add(5, 0, 8'h20, 0, 0, 0, 8'h00, 0);
    add(3, 0, 8'h20, 0, 0, 0, 8'h20, 0);
    add(1, 0, 8'h00, 0, 0, 1, 8'h00, 0);
    add(5, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    // bit 2: first press
    add(5, 0, 8'h04, 0, 0, 0, 8'h00, 0);
    add(1, 0, 8'h04, 0, 0, 0, 8'h04, 0);
    add(6, 0, 8'h00, 0, 0, 0, 8'h04, 0);
    // second press collides with clear of bit 2: bit stays, no overflow
    add(5, 0, 8'h04, 0, 0, 0, 8'h04, 0);
    add(1, 0, 8'h04, 1, 2, 0, 8'h04, 0);
    add(6, 0, 8'h00, 0, 0, 0, 8'h04, 0);
    // third press while pending: overflow, held until clr_all
    add(5, 0, 8'h04, 0, 0, 0, 8'h04, 0);
    add(1, 0, 8'h04, 0, 0, 0, 8'h04, 1);
    add(2, 0, 8'h04, 0, 0, 0, 8'h04, 1);
    add(1, 0, 8'h04, 0, 0, 1, 8'h00, 0);
    add(6, 0, 8'h00, 0, 0, 0, 8'h00, 0);

    foreach (vecs[k]) apply(vecs[k]);

    // Reset mid-debounce: bit 3 pending, bit 0 at count 2 when rst hits.
    seq(5, 0, 8'h08, 0, 0, 0, 8'h00, 0);
    seq(1, 0, 8'h08, 0, 0, 0, 8'h08, 0);
    seq(4, 0, 8'h09, 0, 0, 0, 8'h08, 0);
    seq(1, 1, 8'h09, 0, 0, 0, 8'h00, 0);
    // Held high through reset: exactly one event 6 edges after release.
    seq(5, 0, 8'h09, 0, 0, 0, 8'h00, 0);
    seq(1, 0, 8'h09, 0, 0, 0, 8'h09, 0);
    seq(4, 0, 8'h09, 0, 0, 0, 8'h09, 0);

`ifdef REQ_MASK_EN
    seq(2, 1, 8'h00, 0, 0, 0, 8'h00, 0);
    mask = 8'h01;
    seq(8, 0, 8'h01, 0, 0, 0, 8'h00, 0);
    mask = 8'h00;
    seq(3, 0, 8'h01, 0, 0, 0, 8'h00, 0);
    seq(6, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    seq(5, 0, 8'h01, 0, 0, 0, 8'h00, 0);
    seq(1, 0, 8'h01, 0, 0, 0, 8'h01, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
